// File: rtl/prog_instr_mem.sv
// Program instruction memory: zeroed by a power-up clear sweep, loaded from a
// byte stream (MSB first), and read through a one-cycle registered fetch port.
module prog_instr_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              busy,
    output logic              load_ovf
);

    localparam int NB  = DATA_W / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] clr_ptr_q,     clr_ptr_d;
    logic [ADDR_W-1:0] wptr_q,        wptr_d;
    logic [BCW-1:0]    bcnt_q,        bcnt_d;
    logic [DATA_W-1:0] asm_q,         asm_d;
    logic              load_ovf_q,    load_ovf_d;
    logic [DATA_W-1:0] instr_q,       instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              addr_err_q,    addr_err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] asm_new;
    logic              word_full;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        wptr_d     = wptr_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        load_ovf_d = load_ovf_q;
        mem_we     = 1'b0;
        mem_waddr  = wptr_q;
        // Unfilled low bytes of asm_q are zero, so a short final word pads itself.
        asm_new    = asm_q | (DATA_W'(load_byte) << (DATA_W - 8 - 8 * int'(bcnt_q)));
        mem_wdata  = asm_new;
        word_full  = (int'(bcnt_q) == NB - 1);

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = S_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (load_start) begin
                    state_d    = S_LOAD;
                    wptr_d     = load_base;
                    bcnt_d     = '0;
                    asm_d      = '0;
                    load_ovf_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    if (word_full || load_last) begin
                        mem_we = 1'b1;
                        asm_d  = '0;
                        bcnt_d = '0;
                        if (word_full) begin
                            if (wptr_q == LAST_ADDR) begin
                                wptr_d     = '0;
                                load_ovf_d = 1'b1;
                            end else begin
                                wptr_d = wptr_q + 1'b1;
                            end
                        end
                        if (load_last) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        asm_d  = asm_new;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Fetches are served only in IDLE, so they never collide with a write.
    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        if (fetch_en) begin
            if (state_q != S_IDLE) begin
                instr_d = '0;
            end else if (int'(addr) >= DEPTH) begin
                instr_d       = '0;
                instr_valid_d = 1'b1;
                addr_err_d    = 1'b1;
            end else begin
                instr_d       = mem[addr];
                instr_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            clr_ptr_q     <= '0;
            wptr_q        <= '0;
            bcnt_q        <= '0;
            asm_q         <= '0;
            load_ovf_q    <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wptr_q        <= wptr_d;
            bcnt_q        <= bcnt_d;
            asm_q         <= asm_d;
            load_ovf_q    <= load_ovf_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;
    assign load_ovf    = load_ovf_q;
    assign busy        = (state_q != S_IDLE);
    assign load_ready  = (state_q == S_LOAD);

endmodule

// File: tb/tb_prog_instr_mem.sv
// Bench for prog_instr_mem: directed load/fetch scenarios plus randomized loads
// and fetches checked against a word-array reference model.
module tb_prog_instr_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [7:0]  addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        addr_err;
    logic        load_start;
    logic [7:0]  load_base;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        busy;
    logic        load_ovf;

    logic        f2_en;
    logic [7:0]  f2_addr;
    logic [31:0] instr2;
    logic        instr_valid2;
    logic        addr_err2;
    logic        load_ready2;
    logic        busy2;
    logic        load_ovf2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] model_mem [256];
    bit          model_ovf;
    logic [7:0]  byte_q [$];

    always #5 clock = ~clock;

    prog_instr_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en), .addr(addr),
        .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .busy(busy), .load_ovf(load_ovf)
    );

    prog_instr_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) dut2 (
        .clock(clock), .reset(reset), .fetch_en(f2_en), .addr(f2_addr),
        .instr(instr2), .instr_valid(instr_valid2), .addr_err(addr_err2),
        .load_start(1'b0), .load_base(8'd0), .load_valid(1'b0),
        .load_byte(8'd0), .load_last(1'b0), .load_ready(load_ready2),
        .busy(busy2), .load_ovf(load_ovf2)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        model_ovf = 1'b0;
    endtask

    // Pack byte_q into big-endian words starting at base, wrapping at 256.
    task automatic model_load(input logic [7:0] base);
        int n;
        int nw;
        logic [31:0] w;
        int a;
        n  = byte_q.size();
        nw = (n + 3) / 4;
        model_ovf = 1'b0;
        for (int k = 0; k < nw; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) w[31 - 8 * j -: 8] = byte_q[4 * k + j];
            end
            a = (int'(base) + k) % 256;
            model_mem[a] = w;
            if ((4 * k + 4 <= n) && (a == 255)) model_ovf = 1'b1;
        end
    endtask

    task automatic wait_clear(input string name);
        int cyc;
        int bad;
        cyc = 0;
        bad = 0;
        while (busy && cyc < 400) begin
            step;
            cyc++;
            if (instr_valid !== 1'b0) bad++;
        end
        total_cnt++;
        if (cyc !== 256) $display("FAIL %s_clear_cycles: got %0d want 256", name, cyc);
        else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL %s_valid_during_clear: %0d cycles had instr_valid=1, want 0", name, bad);
        else pass_cnt++;
    endtask

    task automatic fetch_check(input logic [7:0] a, input string name);
        logic [31:0] exp;
        exp = model_mem[a];
        fetch_en = 1'b1;
        addr = a;
        step;
        fetch_en = 1'b0;
        total_cnt++;
        if (instr !== exp || instr_valid !== 1'b1 || addr_err !== 1'b0)
            $display("FAIL %s fetch[%0d]: got instr=%h v=%b e=%b want instr=%h v=1 e=0",
                     name, a, instr, instr_valid, addr_err, exp);
        else pass_cnt++;
    endtask

    // Streams byte_q as one load; optional idle gaps carry fetches and stray
    // load_start pulses, which the DUT must reject while loading.
    task automatic load_seq(input logic [7:0] base, input bit gaps, input string name);
        int n;
        n = byte_q.size();
        load_start = 1'b1;
        load_base  = base;
        step;
        load_start = 1'b0;
        total_cnt++;
        if (load_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL %s_enter_load: ready=%b busy=%b want 1 1", name, load_ready, busy);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    load_valid = 1'b0;
                    fetch_en   = 1'b1;
                    addr       = 8'($urandom);
                    load_start = 1'($urandom_range(0, 1));
                    load_base  = 8'($urandom);
                    step;
                    fetch_en   = 1'b0;
                    load_start = 1'b0;
                    total_cnt++;
                    if (instr_valid !== 1'b0 || instr !== 32'h0 || addr_err !== 1'b0)
                        $display("FAIL %s_fetch_in_load: instr=%h v=%b e=%b want 0 0 0",
                                 name, instr, instr_valid, addr_err);
                    else pass_cnt++;
                end
            end
            load_valid = 1'b1;
            load_byte  = byte_q[i];
            load_last  = (i == n - 1);
            step;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        model_load(base);
        total_cnt++;
        if (busy !== 1'b0 || load_ready !== 1'b0 || load_ovf !== model_ovf)
            $display("FAIL %s_load_done: busy=%b ready=%b ovf=%b want 0 0 %b",
                     name, busy, load_ready, load_ovf, model_ovf);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if (busy !== 1'b1 || load_ready !== 1'b0 || load_ovf !== 1'b0 ||
            instr !== 32'h0 || instr_valid !== 1'b0 || addr_err !== 1'b0)
            $display("FAIL reset_state: busy=%b ready=%b ovf=%b instr=%h v=%b e=%b want 1 0 0 0 0 0",
                     busy, load_ready, load_ovf, instr, instr_valid, addr_err);
        else pass_cnt++;
    endtask

    task automatic test_clear;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        fetch_en = 1'b1;
        addr     = 8'd5;
        wait_clear("power_up");
        step;
        total_cnt++;
        if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_err !== 1'b0)
            $display("FAIL first_fetch: instr=%h v=%b e=%b want 0 1 0", instr, instr_valid, addr_err);
        else pass_cnt++;
        fetch_en = 1'b0;
        model_clear();
    endtask

    task automatic test_basic_load;
        byte_q = '{8'hF2, 8'h80, 8'h00, 8'h32};
        load_seq(8'd9, 1'b0, "basic");
        fetch_check(8'd9, "basic");
        total_cnt++;
        if (instr !== 32'hF2800032) $display("FAIL basic_word: got %h want F2800032", instr);
        else pass_cnt++;
        fetch_en = 1'b0;
        addr = 8'd77;
        step;
        total_cnt++;
        if (instr !== 32'hF2800032 || instr_valid !== 1'b0 || addr_err !== 1'b0)
            $display("FAIL idle_hold: instr=%h v=%b e=%b want F2800032 0 0", instr, instr_valid, addr_err);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        byte_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        load_seq(8'd255, 1'b0, "wrap");
        total_cnt++;
        if (load_ovf !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", load_ovf);
        else pass_cnt++;
        fetch_check(8'd255, "wrap");
        total_cnt++;
        if (instr !== 32'h11121314) $display("FAIL wrap_word255: got %h want 11121314", instr);
        else pass_cnt++;
        fetch_check(8'd0, "wrap");
        total_cnt++;
        if (instr !== 32'h15161718) $display("FAIL wrap_word0: got %h want 15161718", instr);
        else pass_cnt++;
        step;
        total_cnt++;
        if (load_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", load_ovf);
        else pass_cnt++;
    endtask

    task automatic test_partial;
        byte_q = '{8'hAB, 8'hCD};
        load_seq(8'd40, 1'b0, "partial");
        total_cnt++;
        if (load_ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", load_ovf);
        else pass_cnt++;
        fetch_check(8'd40, "partial");
        total_cnt++;
        if (instr !== 32'hABCD0000) $display("FAIL partial_word: got %h want ABCD0000", instr);
        else pass_cnt++;
    endtask

    task automatic test_addr_err;
        f2_en = 1'b1;
        f2_addr = 8'd200;
        step;
        total_cnt++;
        if (instr2 !== 32'h0 || instr_valid2 !== 1'b1 || addr_err2 !== 1'b1)
            $display("FAIL addr_err_200: instr=%h v=%b e=%b want 0 1 1", instr2, instr_valid2, addr_err2);
        else pass_cnt++;
        f2_addr = 8'd199;
        step;
        total_cnt++;
        if (instr2 !== 32'h0 || instr_valid2 !== 1'b1 || addr_err2 !== 1'b0)
            $display("FAIL addr_ok_199: instr=%h v=%b e=%b want 0 1 0", instr2, instr_valid2, addr_err2);
        else pass_cnt++;
        f2_en = 1'b0;
        step;
        total_cnt++;
        if (instr_valid2 !== 1'b0 || addr_err2 !== 1'b0)
            $display("FAIL fetch_off_flags: v=%b e=%b want 0 0", instr_valid2, addr_err2);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [7:0] base;
        logic [7:0] a;
        int n;
        for (int it = 0; it < 30; it++) begin
            base = 8'($urandom);
            n = $urandom_range(1, 10);
            byte_q.delete();
            for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
            load_seq(base, 1'b1, "rand");
            for (int f = 0; f < 3; f++) begin
                if ($urandom_range(0, 1) == 1) a = base + 8'($urandom_range(0, 2));
                else a = 8'($urandom);
                fetch_check(a, "rand");
            end
            addr = 8'($urandom);
            step;
            total_cnt++;
            if (instr !== model_mem[a] || instr_valid !== 1'b0)
                $display("FAIL rand_hold: instr=%h v=%b want %h 0", instr, instr_valid, model_mem[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_load;
        byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_seq(8'd20, 1'b0, "preload");
        fetch_check(8'd20, "preload");
        load_start = 1'b1;
        load_base  = 8'd20;
        step;
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'h5A + 8'(i);
            step;
        end
        load_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b1 || load_ready !== 1'b0 || instr !== 32'h0 || load_ovf !== 1'b0)
            $display("FAIL async_reset: busy=%b ready=%b instr=%h ovf=%b want 1 0 0 0",
                     busy, load_ready, instr, load_ovf);
        else pass_cnt++;
        step;
        step;
        reset = 1'b0;
        model_clear();
        fetch_en = 1'b1;
        addr = 8'd20;
        wait_clear("mid_load");
        fetch_en = 1'b0;
        fetch_check(8'd20, "after_reset");
        total_cnt++;
        if (load_ready !== 1'b0) $display("FAIL after_reset_ready: got %b want 0", load_ready);
        else pass_cnt++;
    endtask

    initial begin
        reset      = 1'b1;
        fetch_en   = 1'b0;
        addr       = 8'd0;
        load_start = 1'b0;
        load_base  = 8'd0;
        load_valid = 1'b0;
        load_byte  = 8'd0;
        load_last  = 1'b0;
        f2_en      = 1'b0;
        f2_addr    = 8'd0;
        model_clear();

        test_reset();
        test_clear();
        test_basic_load();
        test_wrap();
        test_partial();
        test_addr_err();
        test_random();
        test_reset_mid_load();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_instr_mem.md
PROG_INSTR_MEM -- requirements
Module: prog_instr_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8, fetch/load address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of words, at most 2^ADDR_W.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port fetch_en, input, 1, fetch request.
REQ-007 SHALL have port addr, input, ADDR_W, fetch word address.
REQ-008 SHALL have port instr, output, DATA_W, fetched instruction word.
REQ-009 SHALL have port instr_valid, output, 1, instr holds the result of the previous cycle's fetch.
REQ-010 SHALL have port addr_err, output, 1, the previous fetch address was >= DEPTH.
REQ-011 SHALL have port load_start, input, 1, begin a program load.
REQ-012 SHALL have port load_base, input, ADDR_W, first word address of the load.
REQ-013 SHALL have port load_valid, input, 1, load_byte is valid.
REQ-014 SHALL have port load_byte, input, 8, program byte, most significant byte first.
REQ-015 SHALL have port load_last, input, 1, the current byte is the final byte of the load.
REQ-016 SHALL have port load_ready, output, 1, a byte is accepted on cycles where load_valid and load_ready are both 1.
REQ-017 SHALL have port busy, output, 1, the FSM is not in IDLE.
REQ-018 SHALL have port load_ovf, output, 1, sticky flag set when the write pointer wraps.

Function
REQ-019 SHALL implement FSM states CLEAR, IDLE and LOAD.
REQ-020 CLEAR SHALL write zero to word clr_ptr each cycle, from 0 to DEPTH-1, then go to IDLE; it takes DEPTH cycles.
REQ-021 IDLE with load_start=1 SHALL go to LOAD, set wptr=load_base, clear the byte counter and clear load_ovf.
REQ-022 load_ready SHALL be 1 only in LOAD.
REQ-023 Each accepted byte SHALL shift into the word assembly register; byte 0 is bits [DATA_W-1:DATA_W-8].
REQ-024 When the DATA_W/8-th byte is accepted, the assembled word SHALL be written at wptr in the same edge, wptr SHALL increment and the byte counter SHALL reset.
REQ-025 An accepted byte with load_last=1 SHALL write the word, zero-padding any missing low bytes, then go to IDLE.
REQ-026 wptr SHALL wrap from DEPTH-1 to 0 on increment and set load_ovf; load_ovf SHALL hold until the next load_start or reset.
REQ-027 load_start outside IDLE SHALL be ignored.
REQ-028 A fetch with fetch_en=1 in IDLE SHALL register instr = mem[addr] and set instr_valid=1 on the next edge (1-cycle latency).
REQ-029 A fetch with addr >= DEPTH SHALL return instr=0, instr_valid=1 and addr_err=1.
REQ-030 A fetch in CLEAR or LOAD SHALL return instr=0 (NOP), instr_valid=0 and addr_err=0.
REQ-031 fetch_en=0 SHALL drive instr_valid=0 and addr_err=0 and leave instr holding its value.
REQ-032 A fetch and a word write to the same address on the same edge SHALL be impossible, because fetches are blocked in LOAD.

Reset
REQ-033 reset=1 SHALL immediately force state=CLEAR, clr_ptr=0, wptr=0, byte counter=0, instr=0, instr_valid=0, addr_err=0, load_ready=0, busy=1 and load_ovf=0.
REQ-034 Reset asserted mid-CLEAR or mid-LOAD SHALL abandon the operation; any partial word SHALL be discarded and the clear sweep SHALL restart from 0 after release.
REQ-035 Memory contents SHALL NOT be cleared asynchronously; they are zeroed only by the CLEAR sweep.

Verification
REQ-036 Release reset and hold fetch_en=1, addr=5 -> busy=1 for 256 cycles, instr_valid=0 throughout; afterwards instr=0x00000000, instr_valid=1.
REQ-037 load_start with load_base=9, then bytes F2,80,00,32 (last on byte 4) -> busy falls; a fetch of addr 9 gives 0xF2800032 one cycle later.
REQ-038 Load from base 255 with 8 bytes 11..18 -> mem[255]=0x11121314, mem[0]=0x15161718, load_ovf=1.
REQ-039 Load with 2 bytes AB,CD, last on the second -> word written is 0xABCD0000.
REQ-040 Using DEPTH=200, fetch addr=200 -> instr=0, addr_err=1, instr_valid=1.
REQ-041 Assert reset after 2 bytes of a load -> after the clear sweep, the target word reads 0 and load_ready=0.
